// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the pipeline skid register:
//   - state_e      : occupancy state of the two-entry (MAIN + SKID) register
//   - DEF_DATA_W   : default data payload width
//   - DEF_CTRL_W   : default control payload width
//   - DEF_CNT_W    : default stall counter width
// -----------------------------------------------------------------------------
package pipe_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_CTRL_W = 8;
    localparam int DEF_CNT_W  = 16;

    // EMPTY: nothing held; BUSY: MAIN valid; FULL: MAIN and SKID valid
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

endpackage : pipe_pkg

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Saturating up-counter with synchronous clear.
// Ports:
//   clock  in   rising-edge clock
//   resetn in   asynchronous active-low reset (count -> 0)
//   inc    in   add one this cycle (ignored once count is all-ones)
//   clr    in   zero the count; wins over inc
//   count  out  current count, CNT_W bits
// -----------------------------------------------------------------------------
module sat_counter
    import pipe_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] r_count;
    logic             w_at_max;

    assign w_at_max = (r_count == {CNT_W{1'b1}});
    assign count    = r_count;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (inc && !w_at_max) begin
            r_count <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule : sat_counter

// File: rtl/pipe_skid_reg.sv
// -----------------------------------------------------------------------------
// pipe_skid_reg
// Two-entry pipeline register (MAIN drives the outputs, SKID absorbs one
// overflow beat) carrying a data and a control payload between stages.
// Handshake outputs are decoded purely from the state register, so there is
// no combinational path from out_ready to in_ready.
// Ports:
//   clock, resetn         clock / asynchronous active-low reset
//   in_valid, in_ready    upstream handshake
//   in_data, in_ctrl      upstream payload (DATA_W / CTRL_W bits)
//   out_valid, out_ready  downstream handshake
//   out_data, out_ctrl    downstream payload (straight from MAIN)
//   flush                 squash every held payload, drop same-cycle input
//   clr_cnt               zero the stall counter
//   stall_cnt             cycles spent with out_valid=1 and out_ready=0
// -----------------------------------------------------------------------------
module pipe_skid_reg
    import pipe_pkg::*;
#(
    parameter int          DATA_W       = DEF_DATA_W,
    parameter int          CTRL_W       = DEF_CTRL_W,
    parameter int          CNT_W        = DEF_CNT_W,
    parameter int unsigned CLR_ON_FLUSH = 1
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    input  logic              flush,
    input  logic              clr_cnt,
    output logic [CNT_W-1:0]  stall_cnt
);

    state_e            r_state;
    logic [DATA_W-1:0] r_main_data;
    logic [CTRL_W-1:0] r_main_ctrl;
    logic [DATA_W-1:0] r_skid_data;
    logic [CTRL_W-1:0] r_skid_ctrl;

    logic w_in_fire;
    logic w_out_fire;
    logic w_stall;

    assign out_valid  = (r_state != ST_EMPTY);
    assign in_ready   = (r_state != ST_FULL);
    assign out_data   = r_main_data;
    assign out_ctrl   = r_main_ctrl;

    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = out_valid & out_ready;
    assign w_stall    = out_valid & ~out_ready;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state     <= ST_EMPTY;
            r_main_data <= '0;
            r_main_ctrl <= '0;
            r_skid_data <= '0;
            r_skid_ctrl <= '0;
        end else if (flush) begin
            // Squash wins over every transition; any same-cycle input is dropped
            r_state <= ST_EMPTY;
            if (CLR_ON_FLUSH != 0) begin
                r_main_data <= '0;
                r_main_ctrl <= '0;
                r_skid_data <= '0;
                r_skid_ctrl <= '0;
            end
        end else begin
            unique case (r_state)
                ST_EMPTY: begin
                    if (w_in_fire) begin
                        r_main_data <= in_data;
                        r_main_ctrl <= in_ctrl;
                        r_state     <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (w_in_fire && w_out_fire) begin
                        r_main_data <= in_data;
                        r_main_ctrl <= in_ctrl;
                    end else if (w_in_fire) begin
                        // Downstream stalled: park the new beat behind MAIN
                        r_skid_data <= in_data;
                        r_skid_ctrl <= in_ctrl;
                        r_state     <= ST_FULL;
                    end else if (w_out_fire) begin
                        r_state <= ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    // in_ready is low here, so only a drain can happen
                    if (w_out_fire) begin
                        r_main_data <= r_skid_data;
                        r_main_ctrl <= r_skid_ctrl;
                        r_state     <= ST_BUSY;
                    end
                end
                default: begin
                    r_state <= ST_EMPTY;
                end
            endcase
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clock  (clock),
        .resetn (resetn),
        .inc    (w_stall),
        .clr    (clr_cnt),
        .count  (stall_cnt)
    );

endmodule : pipe_skid_reg

// File: tb/tb_pipe_skid_reg.sv
// -----------------------------------------------------------------------------
// tb_pipe_skid_reg
// Directed bench for pipe_skid_reg (CNT_W=4 so saturation is reachable).
// A queue-based model tracks held payloads and the stall count; a negedge
// process compares the DUT against it every cycle, and directed literal
// expectations pin the model.
// -----------------------------------------------------------------------------
module tb_pipe_skid_reg;

    localparam int DW = 32;
    localparam int CW = 8;
    localparam int NW = 4;

    logic          clock;
    logic          resetn;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic [CW-1:0] in_ctrl;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [CW-1:0] out_ctrl;
    logic          flush;
    logic          clr_cnt;
    logic [NW-1:0] stall_cnt;

    int checks   = 0;
    int failures = 0;

    pipe_skid_reg #(
        .DATA_W       (DW),
        .CTRL_W       (CW),
        .CNT_W        (NW),
        .CLR_ON_FLUSH (1)
    ) dut (
        .clock     (clock),
        .resetn    (resetn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ctrl   (in_ctrl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ctrl  (out_ctrl),
        .flush     (flush),
        .clr_cnt   (clr_cnt),
        .stall_cnt (stall_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Queue of held beats {ctrl,data}, oldest first, capacity 2.
    logic [CW+DW-1:0] mq[$];
    int               m_cnt = 0;

    always @(posedge clock) begin
        if (resetn) begin
            automatic bit m_ov     = (mq.size() > 0);
            automatic bit m_ir     = (mq.size() < 2);
            automatic bit in_fire  = in_valid && m_ir;
            automatic bit out_fire = m_ov && out_ready;
            if (clr_cnt)
                m_cnt = 0;
            else if (m_ov && !out_ready && m_cnt < (1 << NW) - 1)
                m_cnt = m_cnt + 1;
            if (flush) begin
                mq.delete();
            end else begin
                if (out_fire) begin
                    $display("xfer out ctrl=%0h data=%0h", mq[0][CW+DW-1:DW], mq[0][DW-1:0]);
                    void'(mq.pop_front());
                end
                if (in_fire)
                    mq.push_back({in_ctrl, in_data});
            end
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clock) begin
        if (resetn) begin
            chk("m_out_valid", 64'(out_valid), 64'(mq.size() > 0));
            chk("m_in_ready", 64'(in_ready), 64'(mq.size() < 2));
            chk("m_stall_cnt", 64'(stall_cnt), 64'(m_cnt));
            if (mq.size() > 0) begin
                chk("m_out_data", 64'(out_data), 64'(mq[0][DW-1:0]));
                chk("m_out_ctrl", 64'(out_ctrl), 64'(mq[0][CW+DW-1:DW]));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    // Advance one cycle; inputs change 2 time units after the rising edge.
    task automatic step();
        @(posedge clock);
        #2;
    endtask

    task automatic drive(input bit v, input logic [DW-1:0] d, input logic [CW-1:0] c, input bit ordy);
        in_valid  = v;
        in_data   = d;
        in_ctrl   = c;
        out_ready = ordy;
    endtask

    // Reset pulse between edges: checks the outputs with no clock edge.
    task automatic reset_pulse(input string tag);
        resetn = 1'b0;
        #1;
        mq.delete();
        m_cnt = 0;
        chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        chk({tag, "_out_data"}, 64'(out_data), 64'd0);
        chk({tag, "_out_ctrl"}, 64'(out_ctrl), 64'd0);
        chk({tag, "_stall_cnt"}, 64'(stall_cnt), 64'd0);
        resetn = 1'b1;
    endtask

    // Mixed handshake table: {in_valid, out_ready} per cycle
    logic [1:0] mix_tab [16] = '{2'b10, 2'b10, 2'b11, 2'b01, 2'b11, 2'b10, 2'b11, 2'b00,
                                 2'b01, 2'b11, 2'b11, 2'b10, 2'b01, 2'b01, 2'b10, 2'b01};

    initial begin
        resetn  = 1'b1;
        flush   = 1'b0;
        clr_cnt = 1'b0;
        drive(1'b0, '0, '0, 1'b0);
        #1;
        reset_pulse("rst_init");

        // ---- streaming 1,2,3,4 ----
        step();
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, DW'(i), CW'(8'hC0 + i), 1'b1);
            step();
            chk($sformatf("stream_data%0d", i), 64'(out_data), 64'(i));
            chk($sformatf("stream_rdy%0d", i), 64'(in_ready), 64'd1);
        end
        drive(1'b0, '0, '0, 1'b1);
        step();
        chk("stream_drained", 64'(out_valid), 64'd0);

        // ---- back-pressure A=0x11, B=0x22 ----
        clr_cnt = 1'b1;
        drive(1'b0, '0, '0, 1'b0);
        step();
        clr_cnt = 1'b0;
        drive(1'b1, 32'h11, 8'hA1, 1'b0);
        step();
        drive(1'b1, 32'h22, 8'hA2, 1'b0);
        step();
        drive(1'b0, '0, '0, 1'b0);
        chk("bp_full_in_ready", 64'(in_ready), 64'd0);
        chk("bp_hold_data", 64'(out_data), 64'h11);
        step();
        chk("bp_still_held", 64'(out_data), 64'h11);
        chk("bp_stall2", 64'(stall_cnt), 64'd2);
        out_ready = 1'b1;
        step();
        chk("bp_second", 64'(out_data), 64'h22);
        chk("bp_second_ctrl", 64'(out_ctrl), 64'hA2);
        step();
        chk("bp_empty", 64'(out_valid), 64'd0);
        chk("bp_stall_final", 64'(stall_cnt), 64'd2);

        // ---- flush in FULL with a same-cycle input ----
        drive(1'b1, 32'h44, 8'hB4, 1'b0);
        step();
        drive(1'b1, 32'h55, 8'hB5, 1'b0);
        step();
        chk("fl_full", 64'(in_ready), 64'd0);
        flush = 1'b1;
        drive(1'b1, 32'h33, 8'hB3, 1'b0);
        step();
        flush = 1'b0;
        drive(1'b0, '0, '0, 1'b1);
        chk("fl_out_valid", 64'(out_valid), 64'd0);
        chk("fl_in_ready", 64'(in_ready), 64'd1);
        chk("fl_main_zero", 64'(out_data), 64'd0);
        chk("fl_ctrl_zero", 64'(out_ctrl), 64'd0);
        chk("fl_skid_zero", 64'(dut.r_skid_data), 64'd0);
        step();
        chk("fl_no_33", 64'(out_valid), 64'd0);

        // ---- saturation ----
        clr_cnt = 1'b1;
        drive(1'b1, 32'h66, 8'hC6, 1'b0);
        step();
        clr_cnt = 1'b0;
        drive(1'b0, '0, '0, 1'b0);
        for (int i = 0; i < 20; i++) step();
        chk("sat_15", 64'(stall_cnt), 64'd15);
        clr_cnt = 1'b1;
        step();
        chk("sat_clr_wins", 64'(stall_cnt), 64'd0);
        clr_cnt = 1'b0;
        step();
        chk("sat_resume", 64'(stall_cnt), 64'd1);

        // ---- reset mid-operation while holding 0x66 ----
        reset_pulse("rst_mid");
        drive(1'b1, 32'h77, 8'hC7, 1'b1);
        step();
        chk("rst_first_valid", 64'(out_valid), 64'd1);
        chk("rst_first_data", 64'(out_data), 64'h77);

        // ---- mixed handshake table, model-checked every cycle ----
        for (int i = 0; i < 16; i++) begin
            drive(mix_tab[i][1], DW'(32'h100 + i), CW'(i), mix_tab[i][0]);
            step();
        end
        drive(1'b0, '0, '0, 1'b1);
        step();
        step();
        chk("end_empty", 64'(out_valid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_pipe_skid_reg

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 Parameter DATA_W, default 32, width of the data payload (ALU result, store data).
REQ-002 Parameter CTRL_W, default 8, width of the control payload (write-enable, mem-to-reg, dest register bits).
REQ-003 Parameter CNT_W, default 16, width of the stall counter.
REQ-004 Parameter CLR_ON_FLUSH, default 1; 1 zeroes stored payloads on flush, 0 leaves them unchanged.
REQ-005 clock  input  1  sole clock; all state updates on its rising edge.
REQ-006 resetn  input  1  reset, asynchronous, active-low.
REQ-007 in_valid  input  1  upstream stage presents a payload.
REQ-008 in_ready  output  1  block can accept a payload this cycle.
REQ-009 in_data  input  DATA_W  upstream data payload.
REQ-010 in_ctrl  input  CTRL_W  upstream control payload.
REQ-011 out_valid  output  1  downstream payload valid.
REQ-012 out_ready  input  1  downstream stage accepts the payload.
REQ-013 out_data  output  DATA_W  downstream data payload.
REQ-014 out_ctrl  output  CTRL_W  downstream control payload.
REQ-015 flush  input  1  kill all held payloads (branch/exception squash).
REQ-016 clr_cnt  input  1  synchronous clear of stall_cnt.
REQ-017 stall_cnt  output  CNT_W  count of downstream back-pressure cycles.

Function
REQ-018 The block SHALL hold two entries: MAIN (drives out_*) and SKID (overflow); in-fire = in_valid & in_ready; out-fire = out_valid & out_ready.
REQ-019 The block SHALL implement the states EMPTY, BUSY (MAIN valid) and FULL (MAIN and SKID valid).
REQ-020 The block SHALL decode out_valid = (state != EMPTY) and in_ready = (state != FULL) directly from the state register, with no combinational path from out_ready to in_ready.
REQ-021 In EMPTY, in-fire SHALL load MAIN and enter BUSY; otherwise the block SHALL stay in EMPTY.
REQ-022 In BUSY: in-fire with out-fire SHALL load MAIN and stay BUSY; in-fire alone SHALL load SKID and enter FULL; out-fire alone SHALL enter EMPTY; neither SHALL hold state.
REQ-023 In FULL, out-fire SHALL copy SKID into MAIN and enter BUSY; otherwise the block SHALL hold state.
REQ-024 Latency from in-fire in EMPTY to out_valid SHALL be exactly 1 cycle; payloads SHALL leave in acceptance order, and none SHALL be lost or duplicated.
REQ-025 flush SHALL take priority over all transitions: next state EMPTY, and any in-fire in the same cycle SHALL be discarded.
REQ-026 With CLR_ON_FLUSH=1, flush SHALL zero MAIN and SKID payloads; with CLR_ON_FLUSH=0, it SHALL leave payload bits unchanged.
REQ-027 stall_cnt SHALL increment by 1 on each cycle with out_valid=1 and out_ready=0, and SHALL saturate at all-ones without wrapping.
REQ-028 clr_cnt SHALL zero stall_cnt and SHALL override an increment in the same cycle; flush SHALL NOT affect stall_cnt.
REQ-029 While out_valid=1 and out_ready=0, out_data and out_ctrl SHALL remain stable unless flush is asserted.

Reset
REQ-030 When resetn=0, the block SHALL immediately set state=EMPTY, MAIN=0, SKID=0 and stall_cnt=0, giving out_valid=0, in_ready=1, out_data=0 and out_ctrl=0, independent of clock.
REQ-031 Reset asserted mid-operation SHALL discard all held payloads; the first rising edge after deassertion SHALL behave as in EMPTY.

Structure
REQ-032 The state encoding enum and default widths (DATA_W, CTRL_W, CNT_W) SHALL live in shared package pipe_pkg.
REQ-033 The stall counter SHALL be one sub-module, sat_counter (parameter CNT_W; ports inc, clr, count).

Verification
REQ-034 Reset: pulse resetn low between edges -> out_valid=0, in_ready=1, out_data=0 and stall_cnt=0 with no clock edge.
REQ-035 Streaming: in_valid=1, out_ready=1, data 1,2,3,4 -> out_data 1,2,3,4 on consecutive cycles starting 1 cycle later; in_ready constant 1.
REQ-036 Back-pressure: send A=0x11, B=0x22 with out_ready=0 -> FULL, in_ready=0, out_data=0x11 held; raise out_ready -> 0x11 then 0x22, stall_cnt=2.
REQ-037 Flush: in FULL, assert flush with in_valid=1 and data 0x33 -> next cycle EMPTY, out_valid=0, 0x33 never appears, data regs=0 (CLR_ON_FLUSH=1).
REQ-038 Saturation: CNT_W=4, hold out_ready=0 for 20 cycles -> stall_cnt=15; clr_cnt=1 alongside stall -> stall_cnt=0.
